// File: rtl/piso_shifter_pkg.sv
// Shared constants for the serialiser and its downstream serial sink stages:
// controller state encodings and a constant-evaluable ceil(log2) helper.
package piso_shifter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shifter_shift_bit.sv
// One bit slice of the serialiser: a plain D flop fed by a load/shift/hold mux,
// cleared synchronously by gating the mux output with the reset.
module shift_bit (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic shift,
  input  logic par_in,
  input  logic ser_in,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = par_in;
    end else if (shift) begin
      q_d = ser_in;
    end
    q_d = q_d & ~reset;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift stage: accepts a word over valid/ready and emits
// it one bit per enabled clock, framed by sout_valid and sout_last.
module piso_shifter
  import piso_shifter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output state_e           dbg_state
);

  // Handshake: a word transfers on the posedge where in_valid && in_ready;
  // in_ready is combinational and never depends on in_valid.
  localparam int CNT_W = CLOG2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q;
  logic             at_last;
  logic             load;
  logic             shift;

  always_comb begin
    at_last  = (cnt_q == LAST_CNT);
    in_ready = !reset && ((state_q == ST_IDLE) ||
                          ((state_q == ST_SHIFT) && shift_en && at_last));
    load     = in_valid && in_ready;
    shift    = (state_q == ST_SHIFT) && shift_en;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (load) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
    end else if (shift) begin
      if (at_last) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shifting on the final bit pushes the last live bit out behind the zero
  // fill, which leaves the register cleared when the block drops to IDLE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ser_in;
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_fill
        assign ser_in = 1'b0;
      end else begin : g_link
        assign ser_in = shreg_q[i-1];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_fill
        assign ser_in = 1'b0;
      end else begin : g_link
        assign ser_in = shreg_q[i+1];
      end
    end

    shift_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .par_in(in_data[i]),
      .ser_in(ser_in),
      .q     (shreg_q[i])
    );
  end

  assign sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = (state_q == ST_SHIFT);
  assign sout_last  = sout_valid && at_last;
  assign dbg_state  = state_q;

endmodule
